// File: rtl/addr_gen_2d.sv
// 2-D address generator: walks (i, j) over a rows x cols grid, one address per accepted advance.
// Optional column-major walk order is enabled by defining ADDR_GEN_COLMAJOR_EN.
module addr_gen_2d #(
  parameter int IW = 2,
  parameter int JW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          active,
  input  logic [IW-1:0] rows_m1,
  input  logic [JW-1:0] cols_m1,
`ifdef ADDR_GEN_COLMAJOR_EN
  input  logic          colmajor,
`endif
  output logic [IW-1:0] iOut,
  output logic [JW-1:0] jOut,
  output logic          valid,
  output logic          last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d, rows_q, rows_d;
  logic [JW-1:0] j_q, j_d, cols_q, cols_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cm_q, cm_d;
  logic          i_end_s, j_end_s, last_s, cm_in_s;

`ifdef ADDR_GEN_COLMAJOR_EN
  assign cm_in_s = colmajor;
`else
  assign cm_in_s = 1'b0;
`endif

  assign i_end_s = (i_q == rows_q);
  assign j_end_s = (j_q == cols_q);
  assign last_s  = valid_q && i_end_s && j_end_s;

  // Next-state and next-output logic for the sweep FSM
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cm_d    = cm_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = rows_m1;
          cols_d  = cols_m1;
          cm_d    = cm_in_s;
          i_d     = {IW{1'b0}};
          j_d     = {JW{1'b0}};
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (active && last_s) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          i_d     = {IW{1'b0}};
          j_d     = {JW{1'b0}};
        end else if (active) begin
          // Fast index wraps at its bound and carries into the slow index
          if (cm_q) begin
            if (i_end_s) begin
              i_d = {IW{1'b0}};
              j_d = j_q + JW'(1);
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            if (j_end_s) begin
              j_d = {JW{1'b0}};
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        i_d     = {IW{1'b0}};
        j_d     = {JW{1'b0}};
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, address and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= {IW{1'b0}};
      j_q     <= {JW{1'b0}};
      rows_q  <= {IW{1'b0}};
      cols_q  <= {JW{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cm_q    <= cm_d;
    end
  end

  assign iOut  = i_q;
  assign jOut  = j_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign last  = last_s;

endmodule

// File: tb/tb_addr_gen_2d.sv
// Self-checking bench for addr_gen_2d: directed and randomized sweeps against a
// queue-based reference list of expected addresses.
module tb_addr_gen_2d;

  localparam int IW = 2;
  localparam int JW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          active;
  logic [IW-1:0] rows_m1;
  logic [JW-1:0] cols_m1;
`ifdef ADDR_GEN_COLMAJOR_EN
  logic          colmajor;
`endif
  logic [IW-1:0] iOut;
  logic [JW-1:0] jOut;
  logic          valid;
  logic          last;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int i;
    int j;
  } addr_t;

  addr_gen_2d #(.IW(IW), .JW(JW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .active  (active),
    .rows_m1 (rows_m1),
    .cols_m1 (cols_m1),
`ifdef ADDR_GEN_COLMAJOR_EN
    .colmajor(colmajor),
`endif
    .iOut    (iOut),
    .jOut    (jOut),
    .valid   (valid),
    .last    (last),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic eb, input logic ed,
                           input logic el, input int ei, input int ej);
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".busy"},  32'(busy),  32'(eb));
    chk({tag, ".done"},  32'(done),  32'(ed));
    chk({tag, ".last"},  32'(last),  32'(el));
    chk({tag, ".i"},     32'(iOut),  32'(ei));
    chk({tag, ".j"},     32'(jOut),  32'(ej));
  endtask

  // mode: 0 = active held high, 1 = toggled 1,0,1..., 2 = random
  task automatic run_sweep(input string tag, input int r, input int c, input int cm,
                           input int mode, input bit disturb, input int rst_at);
    addr_t exp_q[$];
    addr_t a;
    int    n, k, cyc;
    logic  act;
    bit    tog;
    exp_q = {};
    if (cm != 0) begin
      for (int jj = 0; jj <= c; jj++)
        for (int ii = 0; ii <= r; ii++) begin a.i = ii; a.j = jj; exp_q.push_back(a); end
    end else begin
      for (int ii = 0; ii <= r; ii++)
        for (int jj = 0; jj <= c; jj++) begin a.i = ii; a.j = jj; exp_q.push_back(a); end
    end
    n = exp_q.size();
    start   = 1'b1;
    rows_m1 = IW'(r);
    cols_m1 = JW'(c);
`ifdef ADDR_GEN_COLMAJOR_EN
    colmajor = (cm != 0);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0; tog = 1'b1;
    while (k < n && cyc < 400) begin
      check_out({tag, ".addr"}, 1'b1, 1'b1, 1'b0, (k == n - 1), exp_q[k].i, exp_q[k].j);
      if (rst_at == k) begin
        rst = 1'b0;
        #1;
        check_out({tag, ".async_rst"}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        active = 1'b0;
        @(posedge clk); #1;
        check_out({tag, ".in_rst"}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_out({tag, ".after_rst"}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        return;
      end
      case (mode)
        0:       act = 1'b1;
        1:       begin act = tog; tog = ~tog; end
        default: act = 1'($urandom_range(0, 1));
      endcase
      active = act;
      if (disturb && cyc == 1) begin
        start   = 1'b1;
        rows_m1 = ~rows_m1;
        cols_m1 = ~cols_m1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (act) k++;
      cyc++;
    end
    active = 1'b0;
    start  = 1'b0;
    chk({tag, ".consumed"}, 32'(k), 32'(n));
    check_out({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    @(posedge clk); #1;
    check_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; active = 1'b0;
    rows_m1 = '0; cols_m1 = '0;
`ifdef ADDR_GEN_COLMAJOR_EN
    colmajor = 1'b0;
`endif
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_out("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    // start ignored only outside IDLE; here nothing pending so still idle
    run_sweep("full4x4",  3, 3, 0, 0, 1'b0, -1);
    run_sweep("toggle",   1, 2, 0, 1, 1'b0, -1);
    run_sweep("one",      0, 0, 0, 0, 1'b0, -1);
    run_sweep("disturb",  2, 3, 0, 1, 1'b1, -1);
    run_sweep("newsize",  0, 1, 0, 0, 1'b0, -1);
    run_sweep("rst_mid",  3, 3, 0, 0, 1'b0, 9);
    run_sweep("restart",  3, 3, 0, 0, 1'b0, -1);
    for (int s = 0; s < 8; s++) begin
      run_sweep("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 2, 1'b0, -1);
    end
`ifdef ADDR_GEN_COLMAJOR_EN
    run_sweep("colmajor", 2, 1, 1, 0, 1'b0, -1);
    run_sweep("cm_off",   2, 1, 0, 0, 1'b0, -1);
    for (int s = 0; s < 6; s++) begin
      run_sweep("cm_rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), 2, 1'b0, -1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_gen_2d.md
Name: addr_gen_2d

Overview:
- Parametrised 2-D address generator for the matrix datapath.
- Walks (i, j) over a runtime-configurable rows x cols grid, one address per advance. Row-major order by default.
- start/busy/done handshake and per-address valid/last flags.
- Successor to the fixed 4x4 read counter; feeds read ports of the memory/PE array.

Parameters:
- IW, 2, width of row index iOut; max rows = 2^IW
- JW, 2, width of column index jOut; max cols = 2^JW

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin a sweep; sampled only in IDLE
- active  in  1  advance enable; consumes the current address when valid=1
- rows_m1  in  IW  number of rows minus 1; latched at accepted start
- cols_m1  in  JW  number of columns minus 1; latched at accepted start
- iOut  out  IW  current row index
- jOut  out  JW  current column index
- valid  out  1  iOut/jOut hold a live address
- last  out  1  current address is the final one of the sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after the final address is consumed

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; iOut=0, jOut=0; valid=0, last=0, busy=0, done=0; latched rows/cols=0.
- All outputs are registered except last = valid && (i==rows_r) && (j==cols_r).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches rows_m1/cols_m1 into rows_r/cols_r, loads i=0, j=0, and goes to RUN.
  - From the next cycle: valid=1, busy=1.
  - Latency from start to first address: 1 cycle.
- RUN:
  - active=0: hold address and flags.
  - active=1 and not last: j=j+1. When j==cols_r, j wraps to 0 and i=i+1 in the same edge.
  - active=1 and last: go to DONE; valid=0, busy=0, done=1; iOut/jOut return to 0.
- DONE: lasts exactly 1 cycle; done=1; next state IDLE with done=0.
- start in RUN or DONE is ignored; it is not queued.
- rows_m1/cols_m1 changes during RUN have no effect.
- Degenerate 1x1 (rows_m1=0, cols_m1=0):
  - First address has valid=1 and last=1 together.
  - One active cycle completes the sweep.
- Full-size sweep (all-ones rows_m1/cols_m1): i and j never overflow; i is not incremented past rows_r.
- Total addresses per sweep = (rows_m1+1)*(cols_m1+1); each is presented exactly once.
- Reset asserted mid-sweep: immediate return to the reset values; no done pulse is generated.

Optional Feature:
- Macro: ADDR_GEN_COLMAJOR_EN.
- Defined:
  - Adds input port colmajor (1 bit), latched at accepted start.
  - colmajor=1: i is the fast index. i wraps at rows_r, then j increments.
  - last and done rules are unchanged.
  - colmajor=0: identical to row-major.
- Undefined: port absent; generator is always row-major.

Test Plan:
- IW=JW=2, start with rows_m1=3, cols_m1=3, active held 1 -> 16 addresses (0,0),(0,1)…(3,3) on consecutive cycles; last=1 only at (3,3); done=1 the cycle after; busy low with done.
- rows_m1=1, cols_m1=2, active toggled 1,0,1,0… -> address holds on active=0 cycles; sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); done after the 6th consumed address.
- rows_m1=0, cols_m1=0 -> valid=1 and last=1 on the first cycle; one active cycle; done pulse; return to IDLE.
- start re-pulsed and rows_m1 changed mid-RUN -> sequence unaffected; after done, a new start with the new sizes is accepted.
- rst driven 0 at address (2,1) -> outputs immediately at reset values, no done; rst released, start -> sweep restarts at (0,0).
- ADDR_GEN_COLMAJOR_EN defined, colmajor=1, rows_m1=2, cols_m1=1 -> (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); last at (2,1).
